// File: rtl/ex_regbank.sv
// ex_regbank: double-buffered, byte-addressable register bank on the fx bus.
// Shadow bytes are written over fx_*, copied to the active bank on commit, and the
// active bank (or a counter test pattern) drives the wide exp_data output.
module ex_regbank #(
  parameter int unsigned   EXP_W   = 256,
  parameter logic [1023:0] RST_PAT = 1024'h1234567890abcdef55aa55aa55aa55aa,
  parameter logic [7:0]    VERSION = 8'h02
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             fx_wr,
  input  logic [15:0]      fx_waddr,
  input  logic [7:0]       fx_data,
  input  logic             fx_rd,
  input  logic [15:0]      fx_raddr,
  output logic [7:0]       fx_q,
  input  logic [5:0]       mod_id,
  output logic [EXP_W-1:0] exp_data,
  output logic             exp_upd
);

  localparam int unsigned NB    = EXP_W / 8;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned DIV_W = 8;

  localparam logic [7:0] OFF_CTRL   = 8'h80;
  localparam logic [7:0] OFF_STATUS = 8'h81;
  localparam logic [7:0] OFF_VER    = 8'h82;
  localparam logic [7:0] OFF_PATDIV = 8'h83;
  localparam logic [7:0] OFF_LAST   = 8'(NB - 1);

  localparam logic [EXP_W-1:0] RST_V = RST_PAT[EXP_W-1:0];

  // Register state
  logic [EXP_W-1:0] shadow_q,   shadow_d;
  logic [EXP_W-1:0] active_q,   active_d;
  logic [EXP_W-1:0] exp_data_q, exp_data_d;
  logic             exp_upd_q,  exp_upd_d;
  logic             pat_en_q,   pat_en_d;
  logic             auto_q,     auto_d;
  logic             pend_q,     pend_d;
  logic [DIV_W-1:0] pat_div_q,  pat_div_d;
  logic [DIV_W-1:0] div_per_q,  div_per_d;
  logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;
  logic [CNT_W-1:0] pat_cnt_q,  pat_cnt_d;
  logic [7:0]       rdata_q,    rdata_d;

  // Decoded bus strobes
  logic       wsel, rsel;
  logic [7:0] woff, roff;
  logic       shadow_wr, ctrl_wr, div_wr;
  logic       commit;
  logic       pat_rise;
  logic [EXP_W-1:0] pat_vec;

  // Upper address bits are don't-care for decode
  logic unused_addr;
  assign unused_addr = ^{fx_waddr[15:14], fx_raddr[15:14]};

  // Module select and offset decode for both ports
  always_comb begin
    wsel      = fx_wr && (fx_waddr[13:8] == mod_id);
    rsel      = fx_rd && (fx_raddr[13:8] == mod_id);
    woff      = fx_waddr[7:0];
    roff      = fx_raddr[7:0];
    shadow_wr = wsel && (32'(woff) < NB);
    ctrl_wr   = wsel && (woff == OFF_CTRL);
    div_wr    = wsel && (woff == OFF_PATDIV);
    // Auto-commit fires on the last shadow byte; AUTO_COMMIT lives in a different
    // register, so its pre-write value is the one that applies.
    commit    = (ctrl_wr && fx_data[0]) || (auto_q && shadow_wr && (woff == OFF_LAST));
  end

  // Shadow bank byte write and commit into the active bank
  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned i = 0; i < NB; i++) begin
      if (shadow_wr && (woff == 8'(i))) begin
        shadow_d[8*i +: 8] = fx_data;
      end
    end
    // The committed image includes a byte written on the same edge
    active_d  = commit ? shadow_d : active_q;
    exp_upd_d = commit;
    if (commit) begin
      pend_d = 1'b0;
    end else if (shadow_wr) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Control and divider-period registers
  always_comb begin
    pat_en_d  = pat_en_q;
    auto_d    = auto_q;
    pat_div_d = pat_div_q;
    if (ctrl_wr) begin
      pat_en_d = fx_data[1];
      auto_d   = fx_data[2];
    end
    if (div_wr) begin
      pat_div_d = fx_data;
    end
    pat_rise = !pat_en_q && pat_en_d;
  end

  // Pattern counter: one step per (period+1) cycles; the period is latched at each
  // reload so a PAT_DIV write mid-count cannot shorten or stretch the current step.
  always_comb begin
    pat_cnt_d = pat_cnt_q;
    div_cnt_d = div_cnt_q;
    div_per_d = div_per_q;
    if (pat_rise) begin
      pat_cnt_d = '0;
      div_cnt_d = '0;
      div_per_d = pat_div_q;
    end else if (pat_en_q) begin
      if (div_cnt_q == div_per_q) begin
        div_cnt_d = '0;
        div_per_d = pat_div_q;
        pat_cnt_d = pat_cnt_q + CNT_W'(1);
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  // Output image: counter replicated across the bus, or the active bank
  always_comb begin
    pat_vec = '0;
    for (int unsigned i = 0; i < EXP_W; i++) begin
      pat_vec[i] = pat_cnt_d[i % CNT_W];
    end
    exp_data_d = pat_en_d ? pat_vec : active_d;
  end

  // Readback mux; reads see pre-write state and idle cycles drive 0 for bus OR-ing
  always_comb begin
    rdata_d = '0;
    if (rsel) begin
      if (32'(roff) < NB) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (roff == 8'(i)) begin
            rdata_d = shadow_q[8*i +: 8];
          end
        end
      end else begin
        case (roff)
          OFF_CTRL:   rdata_d = {5'b0, auto_q, pat_en_q, 1'b0};
          OFF_STATUS: rdata_d = {6'b0, pat_en_q, pend_q};
          OFF_VER:    rdata_d = VERSION;
          OFF_PATDIV: rdata_d = pat_div_q;
          default:    rdata_d = '0;
        endcase
      end
    end
  end

  // State registers
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= RST_V;
      active_q   <= RST_V;
      exp_data_q <= RST_V;
      exp_upd_q  <= 1'b0;
      pat_en_q   <= 1'b0;
      auto_q     <= 1'b0;
      pend_q     <= 1'b0;
      pat_div_q  <= '0;
      div_per_q  <= '0;
      div_cnt_q  <= '0;
      pat_cnt_q  <= '0;
      rdata_q    <= '0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      exp_data_q <= exp_data_d;
      exp_upd_q  <= exp_upd_d;
      pat_en_q   <= pat_en_d;
      auto_q     <= auto_d;
      pend_q     <= pend_d;
      pat_div_q  <= pat_div_d;
      div_per_q  <= div_per_d;
      div_cnt_q  <= div_cnt_d;
      pat_cnt_q  <= pat_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  assign fx_q     = rdata_q;
  assign exp_data = exp_data_q;
  assign exp_upd  = exp_upd_q;

endmodule

// File: tb/tb_ex_regbank.sv
// tb_ex_regbank: random and directed fx-bus traffic against a byte-array model of
// the register bank; a negedge monitor pops expected reads and commit pulses.
module tb_ex_regbank;

  localparam int unsigned EXP_W = 256;
  localparam int unsigned NB    = EXP_W / 8;
  localparam logic [5:0]  MOD   = 6'd5;
  localparam logic [255:0] RST  = 256'h1234567890abcdef55aa55aa55aa55aa;

  logic             clk_sys = 1'b0;
  logic             rst_n;
  logic             fx_wr, fx_rd;
  logic [15:0]      fx_waddr, fx_raddr;
  logic [7:0]       fx_data;
  logic [7:0]       fx_q;
  logic [5:0]       mod_id;
  logic [EXP_W-1:0] exp_data;
  logic             exp_upd;

  ex_regbank #(.EXP_W(EXP_W)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .fx_wr   (fx_wr),
    .fx_waddr(fx_waddr),
    .fx_data (fx_data),
    .fx_rd   (fx_rd),
    .fx_raddr(fx_raddr),
    .fx_q    (fx_q),
    .mod_id  (mod_id),
    .exp_data(exp_data),
    .exp_upd (exp_upd)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_err = 0;

  // Reference model
  logic [7:0]   shadow_m [NB];
  logic [255:0] active_m;
  bit           pend_m, pat_en_m, auto_m;
  logic [7:0]   pat_div_m;
  logic [7:0]   rd_q [$];
  bit           upd_q [$];
  bit           mon_en = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] rep(input logic [31:0] v);
    return {8{v}};
  endfunction

  task automatic init_model();
    logic [255:0] r;
    r = RST;
    for (int i = 0; i < NB; i++) shadow_m[i] = r[8*i +: 8];
    active_m  = RST;
    pend_m    = 0;
    pat_en_m  = 0;
    auto_m    = 0;
    pat_div_m = 8'h00;
    rd_q.delete();
    upd_q.delete();
  endtask

  task automatic do_commit();
    for (int i = 0; i < NB; i++) active_m[8*i +: 8] = shadow_m[i];
    pend_m = 0;
    upd_q.push_back(1'b1);
  endtask

  function automatic logic [7:0] model_rd(input logic [15:0] a);
    logic [7:0] off;
    off = a[7:0];
    if (a[13:8] != MOD) return 8'h00;
    if (int'(off) < NB) return shadow_m[off];
    case (off)
      8'h80:   return {5'b0, auto_m, pat_en_m, 1'b0};
      8'h81:   return {6'b0, pat_en_m, pend_m};
      8'h82:   return 8'h02;
      8'h83:   return pat_div_m;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_wr(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] off;
    off = a[7:0];
    if (a[13:8] != MOD) return;
    if (int'(off) < NB) begin
      shadow_m[off] = d;
      pend_m = 1;
      if (auto_m && int'(off) == NB - 1) do_commit();
    end else if (off == 8'h80) begin
      pat_en_m = d[1];
      auto_m   = d[2];
      if (d[0]) do_commit();
    end else if (off == 8'h83) begin
      pat_div_m = d;
    end
  endtask

  function automatic logic [15:0] ad(input logic [5:0] m, input logic [7:0] off);
    logic [1:0] top;
    top = 2'($urandom);
    return {top, m, off};
  endfunction

  // One bus cycle; read expectation taken before the edge, write applied after it
  task automatic bus(input bit dw, input logic [15:0] wa, input logic [7:0] wd,
                     input bit dr, input logic [15:0] ra);
    logic [7:0] rexp;
    fx_wr = dw; fx_waddr = wa; fx_data = wd;
    fx_rd = dr; fx_raddr = ra;
    rexp = model_rd(ra);
    @(posedge clk_sys);
    if (dr) rd_q.push_back(rexp);
    if (dw) model_wr(wa, wd);
    #1;
    fx_wr = 0; fx_rd = 0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [7:0] d);
    bus(1, ad(MOD, off), d, 0, 16'h0);
  endtask

  task automatic rd(input logic [7:0] off);
    bus(0, 16'h0, 8'h00, 1, ad(MOD, off));
  endtask

  task automatic idle();
    bus(0, 16'h0, 8'h00, 0, 16'h0);
  endtask

  // Monitor: fx_q, exp_upd and (outside pattern mode) exp_data every cycle
  always @(negedge clk_sys) begin
    if (mon_en) begin
      if (rd_q.size() > 0) chk("fx_q", 256'(fx_q), 256'(rd_q.pop_front()));
      else                 chk("fx_q_idle", 256'(fx_q), 256'h0);
      if (upd_q.size() > 0) begin
        void'(upd_q.pop_front());
        chk("exp_upd", 256'(exp_upd), 256'h1);
      end else begin
        chk("exp_upd_idle", 256'(exp_upd), 256'h0);
      end
      if (!pat_en_m) chk("exp_data", exp_data, active_m);
    end
  end

  initial begin
    logic [7:0] off, d;
    int r;
    rst_n = 0; fx_wr = 0; fx_rd = 0; fx_waddr = '0; fx_raddr = '0; fx_data = '0;
    mod_id = MOD;
    init_model();
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    rst_n = 1;
    chk("rst_exp_data", exp_data, RST);
    chk("rst_fx_q", 256'(fx_q), 256'h0);
    chk("rst_exp_upd", 256'(exp_upd), 256'h0);
    mon_en = 1;
    @(posedge clk_sys); #1;

    // Reset readback
    rd(8'h82); rd(8'h81); rd(8'h80); rd(8'h83); rd(8'h00);

    // Shadow writes then commit
    wr(8'h00, 8'hA5); wr(8'(NB - 1), 8'h3C);
    rd(8'h81); idle();
    wr(8'h80, 8'h01);
    chk("commit_lo", 256'(exp_data[7:0]), 256'hA5);
    chk("commit_hi", 256'(exp_data[255:248]), 256'h3C);
    rd(8'h81); rd(8'h80);
    wr(8'h80, 8'h01);
    idle();

    // Decode
    bus(1, ad(6'd6, 8'h00), 8'h77, 0, 16'h0);
    bus(0, 16'h0, 8'h00, 1, ad(6'd6, 8'h00));
    rd(8'h00);
    bus(1, {2'b11, MOD, 8'h01}, 8'h5A, 0, 16'h0);
    rd(8'h01); rd(8'h40); rd(8'h90);
    wr(8'h40, 8'hFF); wr(8'h90, 8'hFF); wr(8'h82, 8'h55); rd(8'h82);
    bus(1, ad(MOD, 8'h02), 8'h99, 1, ad(MOD, 8'h02));
    rd(8'h02);

    // Auto-commit across a full bank write
    wr(8'h80, 8'h04);
    for (int i = 0; i < NB; i++) wr(8'(i), 8'($urandom));
    idle(); idle();
    rd(8'h80);
    wr(8'h80, 8'h00);

    // Random traffic (pattern mode kept off)
    for (int it = 0; it < 400; it++) begin
      bit dw, dr;
      logic [5:0] wm, rm;
      logic [7:0] woff, roff;
      r  = $urandom_range(0, 9);
      dw = $urandom_range(0, 1);
      dr = $urandom_range(0, 1);
      wm = ($urandom_range(0, 4) == 0) ? 6'($urandom) : MOD;
      rm = ($urandom_range(0, 4) == 0) ? 6'($urandom) : MOD;
      woff = (r < 7) ? 8'($urandom_range(0, NB - 1)) : 8'($urandom_range(8'h7E, 8'h84));
      roff = (r < 5) ? 8'($urandom_range(0, NB - 1)) : 8'($urandom);
      d = 8'($urandom);
      if (woff == 8'h80) d = d & 8'h05;
      bus(dw, ad(wm, woff), d, dr, ad(rm, roff));
    end
    wr(8'h80, 8'h00);

    // Pattern mode
    wr(8'h83, 8'h03);
    wr(8'h80, 8'h02);
    chk("pat_first", exp_data, rep(32'h0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_sys); #1;
      chk("pat_hold0", exp_data, rep(32'h0));
    end
    @(posedge clk_sys); #1;
    chk("pat_step1", exp_data, rep(32'h1));
    rd(8'h81);
    wr(8'h00, 8'h11);
    wr(8'h80, 8'h03);
    wr(8'h83, 8'h00);
    repeat (6) idle();
    force dut.pat_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk_sys); #1;
    chk("pat_wrap", exp_data, rep(32'h0));
    release dut.pat_cnt_q;
    idle();
    wr(8'h80, 8'h00);
    chk("pat_off", exp_data, active_m);
    rd(8'h00);

    // Reset during a commit and an in-flight read
    wr(8'h05, 8'hEE);
    fx_wr = 1; fx_waddr = ad(MOD, 8'h80); fx_data = 8'h01;
    fx_rd = 1; fx_raddr = ad(MOD, 8'h05);
    @(posedge clk_sys); #1;
    fx_wr = 0; fx_rd = 0;
    mon_en = 0;
    rst_n = 0;
    #1;
    chk("midrst_exp_data", exp_data, RST);
    chk("midrst_exp_upd", 256'(exp_upd), 256'h0);
    chk("midrst_fx_q", 256'(fx_q), 256'h0);
    init_model();
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    rst_n = 1;
    mon_en = 1;
    @(posedge clk_sys); #1;
    for (int i = 0; i < NB; i++) rd(8'(i));
    rd(8'h80); rd(8'h81); rd(8'h83);
    idle(); idle();
    mon_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
